wb_sim_ctrl: RTL and testbench
==============================

Name: wb_sim_ctrl

Overview:
Synthesisable Wishbone simulation-control slave for SweRVolf-class benches.
- Provides console character output through a buffered FIFO with valid/ready drain, a software exit register, a 64-bit cycle counter, a MAX_CYCLES watchdog and a parametrised-width GPIO output register.
- Replaces ad-hoc bench-level cycle limits and single-bit GPIO tapping with one bus-mapped peripheral on the core's 32-bit Wishbone data bus.

Parameters:
MAX_CYCLES, 0, watchdog limit in clk cycles; 0 disables the watchdog
NUM_GPIO, 64, GPIO output width, 1..64
FIFO_DEPTH, 16, character FIFO entries; power of two, >=2
FIFO_AW, $clog2(FIFO_DEPTH), FIFO pointer width (derived, not overridden)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
i_wb_adr  in  5  byte address [4:0]; only [4:2] decoded
i_wb_dat  in  32  write data
i_wb_sel  in  4  byte lane enables
i_wb_we  in  1  write enable
i_wb_cyc  in  1  bus cycle
i_wb_stb  in  1  strobe
o_wb_rdt  out  32  read data
o_wb_ack  out  1  acknowledge
o_wb_err  out  1  error response
o_char_data  out  8  FIFO head byte
o_char_valid  out  1  FIFO not empty
i_char_ready  in  1  consumer accepts head byte
o_gpio  out  NUM_GPIO  GPIO outputs
o_done  out  1  simulation finished (sticky)
o_pass  out  1  finished with exit code 0
o_timeout  out  1  finished by watchdog
o_exit_code  out  32  last value written to EXIT

Behaviour:
- Reset: all outputs 0; FIFO empty; cycle counter 0; GPIO 0; done/pass/timeout/exit_code 0.
- Bus handshake: request = cyc & stb & !ack & !err. Exactly one of ack/err pulses for one cycle, the cycle after the request. Data and side effects are committed in that response cycle. Back-to-back requests take 2 cycles each. o_wb_rdt is valid with ack and is 0 otherwise.
- Register map, indexed by adr[4:2]:
  - 0 CHAR. Write with sel[0]=1 pushes dat[7:0]. A write with sel[0]=0 is acked without a push. Read returns {24'b0, level}, where level is the FIFO occupancy 0..FIFO_DEPTH, zero-extended.
  - 1 EXIT. Write sets done=1, exit_code=dat and pass=(dat==0); sel is ignored. Read returns exit_code. A second write after done is acked but ignored (first exit wins).
  - 2 CYC_LO. Read returns counter[31:0] and snapshots counter[63:32] into a shadow register.
  - 3 CYC_HI. Read returns the shadow register.
  - 4 GPIO_LO. Per-byte sel writes to gpio[31:0]; bits >= NUM_GPIO are ignored.
  - 5 GPIO_HI. Per-byte sel writes to gpio[63:32]; bits >= NUM_GPIO are ignored.
  - Reads of GPIO_LO/GPIO_HI return the register, zero-filled above NUM_GPIO.
  - 6, 7: no register. Reads and writes respond with err and have no effect.
- Cycle counter: 64-bit, increments every cycle after reset while !done, and freezes when done. Wraps 2^64-1 -> 0.
- Watchdog: if MAX_CYCLES != 0, !done and counter == MAX_CYCLES-1, then on the next edge done=1, timeout=1, pass=0 and exit_code is unchanged. If an EXIT write commits in that same cycle, the EXIT write wins: timeout stays 0.
- FIFO:
  - Push when a CHAR write commits and the FIFO is not full.
  - Pop when o_char_valid & i_char_ready.
  - Full and write: err instead of ack, byte dropped.
  - Simultaneous push and pop: when full, the push is accepted (pop frees the slot) and level is unchanged; when empty, the write is not bypassed (valid rises the next cycle).
  - Pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer bit.
- Done does not block bus access or the FIFO drain.
- Reset mid-transaction: pending ack/err is cleared; the FIFO is flushed.

Test Plan:
- Write CHAR 0x48, 0x69 -> acks at request+1; o_char_valid, o_char_data=0x48 then 0x69 with i_char_ready=1; CHAR read level 2 before drain, 0 after.
- Fill FIFO_DEPTH=16 with i_char_ready=0, then a 17th write -> err=1, ack=0, level=16; drain order matches write order, so no byte is lost or duplicated.
- EXIT write 0 -> done=1, pass=1, exit_code=0, counter frozen. Then EXIT write 5 -> acked, exit_code stays 0.
- MAX_CYCLES=100 with no EXIT -> done=1, timeout=1 at cycle 100 after reset, counter=99 frozen. Also EXIT in the boundary cycle -> timeout=0.
- Counter preset by force to 0x0000_0001_FFFF_FFFF -> CYC_LO read 0xFFFF_FFFF; CYC_HI read on a later cycle returns 1 (snapshot, not live).
- NUM_GPIO=40: GPIO_HI write 0xFFFF_FFFF with sel=4'b0001 -> o_gpio[39:32]=0xFF, readback 0x0000_00FF. Address 6 access -> err, no ack.

Source files
------------

// File: rtl/wb_sim_ctrl.sv
// Wishbone simulation-control slave: console character FIFO, exit register,
// 64-bit cycle counter with watchdog, and a parametrised GPIO output register.
module wb_sim_ctrl #(
    parameter logic [63:0] MAX_CYCLES = 64'd0,
    parameter int          NUM_GPIO   = 64,
    parameter int          FIFO_DEPTH = 16,
    localparam int         FIFO_AW    = $clog2(FIFO_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [4:0]          i_wb_adr,
    input  logic [31:0]         i_wb_dat,
    input  logic [3:0]          i_wb_sel,
    input  logic                i_wb_we,
    input  logic                i_wb_cyc,
    input  logic                i_wb_stb,
    output logic [31:0]         o_wb_rdt,
    output logic                o_wb_ack,
    output logic                o_wb_err,
    output logic [7:0]          o_char_data,
    output logic                o_char_valid,
    input  logic                i_char_ready,
    output logic [NUM_GPIO-1:0] o_gpio,
    output logic                o_done,
    output logic                o_pass,
    output logic                o_timeout,
    output logic [31:0]         o_exit_code
);
    localparam logic [2:0] REG_CHAR    = 3'd0;
    localparam logic [2:0] REG_EXIT    = 3'd1;
    localparam logic [2:0] REG_CYC_LO  = 3'd2;
    localparam logic [2:0] REG_CYC_HI  = 3'd3;
    localparam logic [2:0] REG_GPIO_LO = 3'd4;
    localparam logic [2:0] REG_GPIO_HI = 3'd5;

    logic                ack_r, err_r;
    logic [31:0]         rdt_r;
    logic [7:0]          fifo_mem_r [FIFO_DEPTH];
    logic [FIFO_AW:0]    wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]    level_s;
    logic                fifo_empty_s, fifo_full_s, push_s, pop_s;
    logic [63:0]         cyc_cnt_r;
    logic [31:0]         cyc_hi_r;
    logic                done_r, pass_r, timeout_r;
    logic [31:0]         exit_code_r;
    logic [NUM_GPIO-1:0] gpio_r, gpio_nxt_s;
    logic [63:0]         gpio_rd_s;
    logic [2:0]          idx_s;
    logic                req_s, bad_adr_s, char_drop_s, resp_err_s, wr_ok_s, rd_ok_s;
    logic                exit_wr_s, wd_fire_s, gpio_wr_lo_s, gpio_wr_hi_s;
    logic [31:0]         rd_data_s;
    logic [1:0]          unused_adr_s;

    assign unused_adr_s = i_wb_adr[1:0];
    assign idx_s        = i_wb_adr[4:2];
    assign req_s        = i_wb_cyc & i_wb_stb & ~ack_r & ~err_r;

    // Extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign level_s      = wr_ptr_r - rd_ptr_r;
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[FIFO_AW] != rd_ptr_r[FIFO_AW]) &&
                          (wr_ptr_r[FIFO_AW-1:0] == rd_ptr_r[FIFO_AW-1:0]);
    assign pop_s        = ~fifo_empty_s & i_char_ready;

    assign bad_adr_s    = idx_s[2] & idx_s[1];
    assign char_drop_s  = i_wb_we & (idx_s == REG_CHAR) & i_wb_sel[0] & fifo_full_s & ~pop_s;
    assign resp_err_s   = req_s & (bad_adr_s | char_drop_s);
    assign wr_ok_s      = req_s & i_wb_we & ~resp_err_s;
    assign rd_ok_s      = req_s & ~i_wb_we & ~resp_err_s;
    assign push_s       = wr_ok_s & (idx_s == REG_CHAR) & i_wb_sel[0];
    assign exit_wr_s    = wr_ok_s & (idx_s == REG_EXIT) & ~done_r;
    assign wd_fire_s    = (MAX_CYCLES != 64'd0) & ~done_r & (cyc_cnt_r == (MAX_CYCLES - 64'd1));
    assign gpio_wr_lo_s = wr_ok_s & (idx_s == REG_GPIO_LO);
    assign gpio_wr_hi_s = wr_ok_s & (idx_s == REG_GPIO_HI);

    for (genvar g = 0; g < NUM_GPIO; g++) begin : g_gpio_wr
        localparam int LANE = (g % 32) / 8;
        assign gpio_nxt_s[g] = (((g < 32) ? gpio_wr_lo_s : gpio_wr_hi_s) & i_wb_sel[LANE])
                               ? i_wb_dat[g % 32] : gpio_r[g];
    end

    for (genvar g = 0; g < 64; g++) begin : g_gpio_rd
        if (g < NUM_GPIO) begin : g_on
            assign gpio_rd_s[g] = gpio_r[g];
        end else begin : g_off
            assign gpio_rd_s[g] = 1'b0;
        end
    end

    // Read data multiplexer for the addressed register.
    always_comb begin
        rd_data_s = 32'd0;
        case (idx_s)
            REG_CHAR:    rd_data_s[FIFO_AW:0] = level_s;
            REG_EXIT:    rd_data_s = exit_code_r;
            REG_CYC_LO:  rd_data_s = cyc_cnt_r[31:0];
            REG_CYC_HI:  rd_data_s = cyc_hi_r;
            REG_GPIO_LO: rd_data_s = gpio_rd_s[31:0];
            REG_GPIO_HI: rd_data_s = gpio_rd_s[63:32];
            default:     rd_data_s = 32'd0;
        endcase
    end

    // Character storage; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r[FIFO_AW-1:0]] <= i_wb_dat[7:0];
        end
    end

    // Bus response, FIFO pointers, counter, exit/watchdog status and GPIO.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r       <= 1'b0;
            err_r       <= 1'b0;
            rdt_r       <= 32'd0;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            cyc_cnt_r   <= 64'd0;
            cyc_hi_r    <= 32'd0;
            done_r      <= 1'b0;
            pass_r      <= 1'b0;
            timeout_r   <= 1'b0;
            exit_code_r <= 32'd0;
            gpio_r      <= '0;
        end else begin
            ack_r <= req_s & ~resp_err_s;
            err_r <= resp_err_s;
            rdt_r <= rd_ok_s ? rd_data_s : 32'd0;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{FIFO_AW{1'b0}}, 1'b1};
            end
            if (rd_ok_s && (idx_s == REG_CYC_LO)) begin
                cyc_hi_r <= cyc_cnt_r[63:32];
            end
            // The counter holds its value on the edge that sets done.
            if (!done_r && !exit_wr_s && !wd_fire_s) begin
                cyc_cnt_r <= cyc_cnt_r + 64'd1;
            end
            if (exit_wr_s) begin
                done_r      <= 1'b1;
                exit_code_r <= i_wb_dat;
                pass_r      <= (i_wb_dat == 32'd0);
            end else if (wd_fire_s) begin
                done_r    <= 1'b1;
                timeout_r <= 1'b1;
                pass_r    <= 1'b0;
            end
            gpio_r <= gpio_nxt_s;
        end
    end

    assign o_wb_ack     = ack_r;
    assign o_wb_err     = err_r;
    assign o_wb_rdt     = rdt_r;
    assign o_char_valid = ~fifo_empty_s;
    assign o_char_data  = fifo_empty_s ? 8'd0 : fifo_mem_r[rd_ptr_r[FIFO_AW-1:0]];
    assign o_gpio       = gpio_r;
    assign o_done       = done_r;
    assign o_pass       = pass_r;
    assign o_timeout    = timeout_r;
    assign o_exit_code  = exit_code_r;
endmodule

// File: tb/tb_wb_sim_ctrl.sv
// Self-checking bench for wb_sim_ctrl: a 40-bit GPIO instance without watchdog
// and a 100-cycle watchdog instance, checked against a queue/array reference.
module tb_wb_sim_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0, w_rst = 1'b0;
    logic [4:0]  adr = 5'd0, w_adr = 5'd0;
    logic [31:0] dat = 32'd0, w_dat = 32'd0;
    logic [3:0]  sel = 4'd0, w_sel = 4'd0;
    logic        we = 1'b0, cyc = 1'b0, stb = 1'b0, char_ready = 1'b0;
    logic        w_we = 1'b0, w_cyc = 1'b0, w_stb = 1'b0, w_char_ready = 1'b0;
    logic [31:0] rdt, w_rdt, exit_code, w_exit_code;
    logic        ack, err, char_valid, done, pass, timeout;
    logic        w_ack, w_err, w_char_valid, w_done, w_pass, w_timeout;
    logic [7:0]  char_data, w_char_data;
    logic [39:0] gpio;
    logic [63:0] w_gpio;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  model_q[$];
    logic [63:0] gpio_m = 64'd0;

    always #5 clk = ~clk;

    wb_sim_ctrl #(.NUM_GPIO(40)) dut (
        .clk(clk), .rst(rst), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc), .i_wb_stb(stb), .o_wb_rdt(rdt), .o_wb_ack(ack),
        .o_wb_err(err), .o_char_data(char_data), .o_char_valid(char_valid),
        .i_char_ready(char_ready), .o_gpio(gpio), .o_done(done), .o_pass(pass),
        .o_timeout(timeout), .o_exit_code(exit_code)
    );

    wb_sim_ctrl #(.MAX_CYCLES(64'd100)) dut_wd (
        .clk(clk), .rst(w_rst), .i_wb_adr(w_adr), .i_wb_dat(w_dat), .i_wb_sel(w_sel),
        .i_wb_we(w_we), .i_wb_cyc(w_cyc), .i_wb_stb(w_stb), .o_wb_rdt(w_rdt), .o_wb_ack(w_ack),
        .o_wb_err(w_err), .o_char_data(w_char_data), .o_char_valid(w_char_valid),
        .i_char_ready(w_char_ready), .o_gpio(w_gpio), .o_done(w_done), .o_pass(w_pass),
        .o_timeout(w_timeout), .o_exit_code(w_exit_code)
    );

    task automatic do_reset(input bit to_wd);
        @(negedge clk);
        if (to_wd) w_rst = 1'b1; else rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (to_wd) w_rst = 1'b0; else rst = 1'b0;
    endtask

    // One single-beat request; response sampled 1 time unit after the next edge.
    task automatic xfer(input bit to_wd, input logic [2:0] idx, input logic [31:0] wdat,
                        input logic [3:0] wsel, input bit wr, input bit rdy,
                        output logic [31:0] r, output logic a, output logic e);
        @(negedge clk);
        for (int t = 0; t < 3; t++) if (to_wd ? (w_ack | w_err) : (ack | err)) @(negedge clk);
        if (to_wd) begin
            w_adr = {idx, 2'b00}; w_dat = wdat; w_sel = wsel; w_we = wr;
            w_cyc = 1'b1; w_stb = 1'b1; w_char_ready = rdy;
        end else begin
            adr = {idx, 2'b00}; dat = wdat; sel = wsel; we = wr;
            cyc = 1'b1; stb = 1'b1; char_ready = rdy;
        end
        @(posedge clk);
        #1;
        if (to_wd) begin
            r = w_rdt; a = w_ack; e = w_err;
            w_cyc = 1'b0; w_stb = 1'b0; w_we = 1'b0; w_char_ready = 1'b0;
        end else begin
            r = rdt; a = ack; e = err;
            cyc = 1'b0; stb = 1'b0; we = 1'b0; char_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        do_reset(1'b0);
        do_reset(1'b1);
        n_cmp++; if ({ack, err, char_valid, done, pass, timeout} !== 6'b0) begin
            n_bad++; $display("FAIL reset_flags: got %b want 000000", {ack, err, char_valid, done, pass, timeout}); end
        n_cmp++; if ({rdt, exit_code, char_data, gpio} !== 112'd0) begin
            n_bad++; $display("FAIL reset_data: got %h want 0", {rdt, exit_code, char_data, gpio}); end
        n_cmp++; if ({w_gpio, w_char_valid, w_char_data, w_done, w_timeout} !== 75'd0) begin
            n_bad++; $display("FAIL reset_wd: got %h want 0", {w_gpio, w_char_valid, w_char_data, w_done, w_timeout}); end
        // request presented in the same cycle as reset must leave no response or push
        @(negedge clk);
        adr = 5'd0; dat = 32'h0000_00AA; sel = 4'h1; we = 1'b1; cyc = 1'b1; stb = 1'b1; rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if ({ack, err, char_valid} !== 3'b000) begin
            n_bad++; $display("FAIL reset_mid_txn: got %b want 000", {ack, err, char_valid}); end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        gpio_m = 64'd0;
        model_q.delete();
    endtask

    task automatic test_char_basic();
        logic [31:0] r; logic a, e;
        xfer(1'b0, 3'd0, 32'h0000_0048, 4'h1, 1'b1, 1'b0, r, a, e); model_q.push_back(8'h48);
        n_cmp++; if ({a, e} !== 2'b10) begin n_bad++; $display("FAIL char_ack0: got %b want 10", {a, e}); end
        xfer(1'b0, 3'd0, 32'hFFFF_FF69, 4'hF, 1'b1, 1'b0, r, a, e); model_q.push_back(8'h69);
        n_cmp++; if ({a, e} !== 2'b10) begin n_bad++; $display("FAIL char_ack1: got %b want 10", {a, e}); end
        xfer(1'b0, 3'd0, 32'h0000_0055, 4'hE, 1'b1, 1'b0, r, a, e);
        n_cmp++; if ({a, e} !== 2'b10) begin n_bad++; $display("FAIL char_nosel_ack: got %b want 10", {a, e}); end
        xfer(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if (r !== 32'd2) begin n_bad++; $display("FAIL char_level2: got %0d want 2", r); end
        char_ready = 1'b1;
        for (int t = 0; t < 6 && model_q.size() > 0; t++) begin
            @(negedge clk);
            n_cmp++; if ({char_valid, char_data} !== {1'b1, model_q[0]}) begin
                n_bad++; $display("FAIL char_drain: got %b/%h want 1/%h", char_valid, char_data, model_q[0]); end
            @(posedge clk);
            void'(model_q.pop_front());
        end
        @(negedge clk);
        char_ready = 1'b0;
        xfer(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if (r !== 32'd0) begin n_bad++; $display("FAIL char_level0: got %0d want 0", r); end
    endtask

    task automatic test_fifo_full();
        logic [31:0] r; logic a, e; logic [7:0] b;
        for (int i = 0; i < 16; i++) begin
            b = 8'($urandom);
            xfer(1'b0, 3'd0, {24'd0, b}, 4'h1, 1'b1, 1'b0, r, a, e);
            model_q.push_back(b);
            n_cmp++; if ({a, e} !== 2'b10) begin n_bad++; $display("FAIL fill_ack[%0d]: got %b want 10", i, {a, e}); end
        end
        xfer(1'b0, 3'd0, 32'h0000_00EE, 4'h1, 1'b1, 1'b0, r, a, e);
        n_cmp++; if ({a, e} !== 2'b01) begin n_bad++; $display("FAIL full_err: got ack/err %b want 01", {a, e}); end
        xfer(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if (r !== 32'd16) begin n_bad++; $display("FAIL full_level: got %0d want 16", r); end
        // push while full and popping in the same cycle is accepted
        b = 8'($urandom);
        xfer(1'b0, 3'd0, {24'd0, b}, 4'h1, 1'b1, 1'b1, r, a, e);
        void'(model_q.pop_front()); model_q.push_back(b);
        n_cmp++; if ({a, e} !== 2'b10) begin n_bad++; $display("FAIL full_pushpop: got %b want 10", {a, e}); end
        xfer(1'b0, 3'd0, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if (r !== 32'd16) begin n_bad++; $display("FAIL pushpop_level: got %0d want 16", r); end
        char_ready = 1'b1;
        for (int t = 0; t < 20 && model_q.size() > 0; t++) begin
            @(negedge clk);
            n_cmp++; if ({char_valid, char_data} !== {1'b1, model_q[0]}) begin
                n_bad++; $display("FAIL full_drain: got %b/%h want 1/%h", char_valid, char_data, model_q[0]); end
            @(posedge clk);
            void'(model_q.pop_front());
        end
        @(negedge clk);
        char_ready = 1'b0;
        n_cmp++; if (char_valid !== 1'b0) begin n_bad++; $display("FAIL drain_empty: got %b want 0", char_valid); end
        // push into empty FIFO with ready high: not bypassed, byte appears next cycle
        b = 8'($urandom);
        xfer(1'b0, 3'd0, {24'd0, b}, 4'h1, 1'b1, 1'b1, r, a, e);
        n_cmp++; if ({a, char_valid, char_data} !== {2'b11, b}) begin
            n_bad++; $display("FAIL empty_nobypass: got %b/%b/%h want 1/1/%h", a, char_valid, char_data, b); end
        @(negedge clk);
        char_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        char_ready = 1'b0;
        n_cmp++; if (char_valid !== 1'b0) begin n_bad++; $display("FAIL empty_drain: got %b want 0", char_valid); end
    endtask

    task automatic test_gpio();
        logic [31:0] r, wd; logic a, e; logic [2:0] idx; logic [3:0] ws;
        for (int i = 0; i < 10; i++) begin
            idx = 3'($urandom_range(4, 5)); wd = $urandom; ws = 4'($urandom_range(0, 15));
            xfer(1'b0, idx, wd, ws, 1'b1, 1'b0, r, a, e);
            for (int k = 0; k < 4; k++) if (ws[k]) gpio_m[((idx == 3'd5) ? 32 : 0) + 8 * k +: 8] = wd[8 * k +: 8];
            gpio_m &= 64'h0000_00FF_FFFF_FFFF;
            n_cmp++; if ({a, gpio} !== {1'b1, gpio_m[39:0]}) begin
                n_bad++; $display("FAIL gpio_write[%0d]: got %b/%h want 1/%h", i, a, gpio, gpio_m[39:0]); end
        end
        xfer(1'b0, 3'd4, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if (r !== gpio_m[31:0]) begin n_bad++; $display("FAIL gpio_rd_lo: got %h want %h", r, gpio_m[31:0]); end
        xfer(1'b0, 3'd5, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if (r !== gpio_m[63:32]) begin n_bad++; $display("FAIL gpio_rd_hi: got %h want %h", r, gpio_m[63:32]); end
        xfer(1'b0, 3'd5, 32'hFFFF_FFFF, 4'b0001, 1'b1, 1'b0, r, a, e);
        gpio_m[39:32] = 8'hFF;
        n_cmp++; if (gpio[39:32] !== 8'hFF) begin n_bad++; $display("FAIL gpio_hi_byte: got %h want ff", gpio[39:32]); end
        xfer(1'b0, 3'd5, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if (r !== 32'h0000_00FF) begin n_bad++; $display("FAIL gpio_hi_mask: got %h want 000000ff", r); end
    endtask

    task automatic test_bad_addr();
        logic [31:0] r; logic a, e;
        for (int i = 0; i < 4; i++) begin
            xfer(1'b0, (i < 2) ? 3'd6 : 3'd7, $urandom, 4'hF, i[0], 1'b0, r, a, e);
            n_cmp++; if ({a, e, r} !== {2'b01, 32'd0}) begin
                n_bad++; $display("FAIL bad_addr[%0d]: got %b/%b/%h want 0/1/0", i, a, e, r); end
        end
        n_cmp++; if ({char_valid, gpio} !== {1'b0, gpio_m[39:0]}) begin
            n_bad++; $display("FAIL bad_addr_effect: got %b/%h want 0/%h", char_valid, gpio, gpio_m[39:0]); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        v = $urandom;
        @(negedge clk);
        @(negedge clk);
        adr = 5'b10000; dat = v; sel = 4'hF; we = 1'b1; cyc = 1'b1; stb = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (ack !== ((k % 2) == 0)) begin
                n_bad++; $display("FAIL b2b_ack[%0d]: got %b want %b", k, ack, (k % 2) == 0); end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        gpio_m[31:0] = v;
        n_cmp++; if (gpio !== gpio_m[39:0]) begin n_bad++; $display("FAIL b2b_gpio: got %h want %h", gpio, gpio_m[39:0]); end
    endtask

    task automatic test_counter();
        logic [31:0] r; logic a, e; int n;
        do_reset(1'b0);
        gpio_m = 64'd0;
        n = $urandom_range(3, 60);
        repeat (n) @(posedge clk);
        xfer(1'b0, 3'd2, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if ({a, r} !== {1'b1, 32'(n)}) begin n_bad++; $display("FAIL cyc_lo: got %b/%0d want 1/%0d", a, r, n); end
        @(negedge clk);
        @(negedge clk);
        force dut.cyc_cnt_r = 64'h0000_0001_FFFF_FFFF;
        adr = 5'b01000; we = 1'b0; cyc = 1'b1; stb = 1'b1;
        #1;
        release dut.cyc_cnt_r;
        @(posedge clk);
        #1;
        n_cmp++; if ({ack, rdt} !== {1'b1, 32'hFFFF_FFFF}) begin
            n_bad++; $display("FAIL cyc_lo_preset: got %b/%h want 1/ffffffff", ack, rdt); end
        cyc = 1'b0; stb = 1'b0;
        repeat (3) @(posedge clk);
        xfer(1'b0, 3'd3, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if (r !== 32'd1) begin n_bad++; $display("FAIL cyc_hi_snapshot: got %h want 1", r); end
    endtask

    task automatic test_exit();
        logic [31:0] r; logic a, e; int n;
        do_reset(1'b0);
        n = $urandom_range(5, 40);
        repeat (n) @(posedge clk);
        xfer(1'b0, 3'd1, 32'd0, 4'h0, 1'b1, 1'b0, r, a, e);
        n_cmp++; if ({a, done, pass, timeout, exit_code} !== {4'b1110, 32'd0}) begin
            n_bad++; $display("FAIL exit0: got %b%b%b%b/%h want 1110/0", a, done, pass, timeout, exit_code); end
        repeat (5) @(posedge clk);
        xfer(1'b0, 3'd2, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if (r !== 32'(n)) begin n_bad++; $display("FAIL exit_frozen: got %0d want %0d", r, n); end
        xfer(1'b0, 3'd1, 32'd5, 4'hF, 1'b1, 1'b0, r, a, e);
        n_cmp++; if ({a, pass, exit_code} !== {2'b11, 32'd0}) begin
            n_bad++; $display("FAIL exit_second: got %b/%b/%h want 1/1/0", a, pass, exit_code); end
        xfer(1'b0, 3'd0, 32'h0000_0021, 4'h1, 1'b1, 1'b0, r, a, e);
        n_cmp++; if ({a, char_valid, char_data} !== {2'b11, 8'h21}) begin
            n_bad++; $display("FAIL char_after_done: got %b/%b/%h want 1/1/21", a, char_valid, char_data); end
    endtask

    task automatic test_watchdog();
        logic [31:0] r; logic a, e;
        do_reset(1'b1);
        for (int k = 1; k <= 100; k++) begin
            @(posedge clk);
            #1;
            if (k == 99) begin
                n_cmp++; if (w_done !== 1'b0) begin n_bad++; $display("FAIL wd_early: got %b want 0", w_done); end
            end
            if (k == 100) begin
                n_cmp++; if ({w_done, w_timeout, w_pass, w_exit_code} !== {3'b110, 32'd0}) begin
                    n_bad++; $display("FAIL wd_fire: got %b%b%b/%h want 110/0", w_done, w_timeout, w_pass, w_exit_code); end
            end
        end
        repeat (4) @(posedge clk);
        xfer(1'b1, 3'd2, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if (r !== 32'd99) begin n_bad++; $display("FAIL wd_frozen: got %0d want 99", r); end
    endtask

    task automatic test_watchdog_boundary();
        logic [31:0] r, code; logic a, e;
        do_reset(1'b1);
        code = $urandom | 32'd1;
        repeat (99) @(posedge clk);
        xfer(1'b1, 3'd1, code, 4'hF, 1'b1, 1'b0, r, a, e);
        n_cmp++; if ({a, w_done, w_timeout, w_pass, w_exit_code} !== {4'b1100, code}) begin
            n_bad++; $display("FAIL wd_exit_wins: got %b%b%b%b/%h want 1100/%h", a, w_done, w_timeout, w_pass, w_exit_code, code); end
        xfer(1'b1, 3'd2, 32'd0, 4'h0, 1'b0, 1'b0, r, a, e);
        n_cmp++; if (r !== 32'd99) begin n_bad++; $display("FAIL wd_exit_cnt: got %0d want 99", r); end
    endtask

    initial begin
        test_reset();
        test_char_basic();
        test_fifo_full();
        test_gpio();
        test_bad_addr();
        test_back_to_back();
        test_counter();
        test_exit();
        test_watchdog();
        test_watchdog_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
